// File: rtl/regdump_pkg.sv
// regdump_pkg: shared FSM state type and default geometry for the register dump reader.
package regdump_pkg;
  localparam int NUM_REGS_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_e;
endpackage

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register file and streams each value out over a valid/ready beat.
// Define REGDUMP_SKIP_R0_EN to start the walk at register 1 (register 0 is never read or emitted).
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] ra_o,
  input  logic [DATA_W-1:0] rd_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              done_o
);
`ifdef REGDUMP_SKIP_R0_EN
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] FIRST_IDX = '0;
`endif
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, didx_q, didx_d;
  logic [DATA_W-1:0] data_q, data_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    didx_d = didx_q;
    data_d = data_q;
    case (state_q)
      IDLE: if (start_i) begin
        idx_d = FIRST_IDX;
        state_d = READ;
      end
      READ: begin
        data_d = rd_i;
        didx_d = idx_q;
        state_d = SEND;
      end
      SEND: if (dump_ready_i) begin
        state_d = (idx_q == LAST_IDX) ? DONE : READ;
        idx_d = (idx_q == LAST_IDX) ? idx_q : idx_q + ADDR_W'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // rst_n is this codebase's active-high asynchronous reset despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      didx_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      didx_q <= didx_d;
      data_q <= data_d;
    end
  end
  assign ra_o = idx_q;
  assign busy_o = state_q != IDLE;
  assign dump_valid_o = state_q == SEND;
  assign done_o = state_q == DONE;
  assign dump_idx_o = didx_q;
  assign dump_data_o = data_q;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: randomized self-checking bench comparing dump beats against a regfile snapshot model.
module tb_regfile_dump_reader;
  localparam int N = 32;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REGDUMP_SKIP_R0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NB = N - FIRST;
  logic clk = 0, rst_n = 1, start_i = 0, dump_ready_i = 1;
  logic busy_o, dump_valid_o, done_o;
  logic [AW-1:0] ra_o, dump_idx_o;
  logic [DW-1:0] rd_i, dump_data_o;
  logic [DW-1:0] rf [N];
  logic [DW-1:0] exp_rf [N];
  int checks = 0, passed = 0, edges = 0, done_cnt = 0, done_edge = -1;
  logic [AW-1:0] bq_idx [$];
  logic [DW-1:0] bq_data [$];
  logic pv = 0, pr = 0;
  logic [AW-1:0] pidx = '0;
  logic [DW-1:0] pdata = '0;
  always #5 clk = ~clk;
  assign rd_i = rf[ra_o];
  regfile_dump_reader #(.NUM_REGS(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .ra_o(ra_o), .rd_i(rd_i),
    .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i), .dump_idx_o(dump_idx_o),
    .dump_data_o(dump_data_o), .done_o(done_o)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(posedge clk) edges <= edges + 1;
  // beats are logged on the falling edge; a held beat must not change while ready is low
  always @(negedge clk) begin
    if (rst_n) pv = 0;
    else begin
      if (pv && !pr) begin
        check("hold_valid", 64'(dump_valid_o), 64'(1));
        check("hold_idx", 64'(dump_idx_o), 64'(pidx));
        check("hold_data", 64'(dump_data_o), 64'(pdata));
      end
      if (dump_valid_o && dump_ready_i) begin
        bq_idx.push_back(dump_idx_o);
        bq_data.push_back(dump_data_o);
      end
      if (done_o) begin
        done_cnt++;
        done_edge = edges;
      end
      pv = dump_valid_o;
      pr = dump_ready_i;
      pidx = dump_idx_o;
      pdata = dump_data_o;
    end
  end
  task automatic check_beats(input string nm, input int b0);
    for (int k = 0; k < NB; k++) begin
      if (b0 + k < bq_idx.size()) begin
        check({nm, "_idx"}, 64'(bq_idx[b0+k]), 64'(FIRST + k));
        check({nm, "_data"}, 64'(bq_data[b0+k]), 64'(exp_rf[FIRST+k]));
      end
    end
  endtask
  task automatic wait_done(input string nm, input int d0, input int rmode, input bit wr7, output int de);
    bit fin = 0;
    int stall = 0;
    de = -1;
    for (int c = 0; c < 2000 && !fin; c++) begin
      @(posedge clk); #1;
      if (!wr7 || 1) ;
      if (wr7 && busy_o && !dump_valid_o && !done_o && ra_o == AW'(7)) begin
        @(posedge clk) rf[7] <= 32'hDEAD_BEEF;
        #1;
      end
      if (rmode == 1) dump_ready_i = 1'($urandom_range(0, 1));
      else if (rmode == 2 && dump_valid_o && dump_idx_o == AW'(FIRST + 5) && stall < 2) begin
        dump_ready_i = 0;
        stall++;
      end else dump_ready_i = 1;
      fin = done_cnt != d0;
      if (fin) de = done_edge;
    end
    check({nm, "_done_seen"}, 64'(fin), 64'(1));
  endtask
  task automatic run_dump(input string nm, input int rmode, input bit hold, input bit wr7);
    int b0, d0, e0, de;
    b0 = bq_idx.size();
    d0 = done_cnt;
    dump_ready_i = 1;
    @(posedge clk); #1;
    start_i = 1;
    e0 = edges + 1;
    @(posedge clk); #1;
    if (!hold) start_i = 0;
    wait_done(nm, d0, rmode, wr7, de);
    check({nm, "_done_pulse"}, 64'(done_o), 64'(0));
    check({nm, "_idle_after_done"}, 64'(busy_o), 64'(0));
    if (rmode == 0) check({nm, "_done_edge"}, 64'(de), 64'(e0 + 2 * NB));
    if (hold) begin
      check({nm, "_done_once"}, 64'(done_cnt - d0), 64'(1));
      check({nm, "_beats_first"}, 64'(bq_idx.size() - b0), 64'(NB));
      @(posedge clk); #1;
      check({nm, "_restart_busy"}, 64'(busy_o), 64'(1));
      start_i = 0;
      wait_done({nm, "_second"}, d0 + 1, 0, 0, de);
      check({nm, "_beats_total"}, 64'(bq_idx.size() - b0), 64'(2 * NB));
    end else check({nm, "_beats"}, 64'(bq_idx.size() - b0), 64'(NB));
    check_beats(nm, b0);
  endtask
  initial begin
    bit found = 0;
    int d0;
    for (int i = 0; i < N; i++) begin
      rf[i] <= 32'h1000_0000 + i;
      exp_rf[i] = 32'h1000_0000 + i;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_valid", 64'(dump_valid_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_ra", 64'(ra_o), 64'(0));
    check("rst_idx", 64'(dump_idx_o), 64'(0));
    check("rst_data", 64'(dump_data_o), 64'(0));
    rst_n = 0;
    run_dump("seq", 0, 0, 0);
    run_dump("stall5", 2, 0, 0);
    run_dump("hold", 0, 1, 0);
    d0 = done_cnt;
    @(posedge clk); #1;
    start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(posedge clk); #1;
      found = dump_valid_o && dump_idx_o == AW'(FIRST + 10);
    end
    check("abort_reached", 64'(found), 64'(1));
    rst_n = 1;
    #1;
    check("abort_valid", 64'(dump_valid_o), 64'(0));
    check("abort_busy", 64'(busy_o), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    @(negedge clk);
    check("abort_idle", 64'(busy_o), 64'(0));
    repeat (3) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'(0));
    run_dump("restart", 0, 0, 0);
    run_dump("wr7", 0, 0, 1);
    exp_rf[7] = 32'hDEAD_BEEF;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        exp_rf[i] = $urandom;
        rf[i] <= exp_rf[i];
      end
      run_dump("rand", 1, 0, 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
